// File: rtl/ili9341_pkg.sv
// Shared ILI9341 definitions: command opcodes, decoder states and coordinate type.
// The panel driver imports the same opcodes.
package ili9341_pkg;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] CMD_RAMWRC  = 8'h3C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET,
    ST_PASET,
    ST_RAMWR,
    ST_IGNORE
  } dec_state_t;

  typedef logic [8:0] coord_t;

endpackage

// File: rtl/ili9341_spi_deser.sv
// Oversampling SPI deserializer: synchronizes the serial pins to clk and
// rebuilds MSB-first bytes, tagging each with its DC level at the 8th bit.
module ili9341_spi_deser
  import ili9341_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_clk,
  input  logic       spi_din,
  input  logic       spi_dc,
  input  logic       spi_cs,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_is_cmd
);

  logic       sclk_p0, sclk_p1, sclk_p2;
  logic       din_p0, din_p1;
  logic       dc_p0, dc_p1;
  logic       cs_p0, cs_p1;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;
  logic       vld_p2;
  logic       rise;

  // Stage p0/p1: two-flop synchronizers; p2 holds the previous synced clock
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_p0 <= 1'b0; sclk_p1 <= 1'b0; sclk_p2 <= 1'b0;
      din_p0  <= 1'b0; din_p1  <= 1'b0;
      dc_p0   <= 1'b0; dc_p1   <= 1'b0;
      cs_p0   <= 1'b0; cs_p1   <= 1'b0;
    end else begin
      sclk_p0 <= spi_clk; sclk_p1 <= sclk_p0; sclk_p2 <= sclk_p1;
      din_p0  <= spi_din; din_p1  <= din_p0;
      dc_p0   <= spi_dc;  dc_p1   <= dc_p0;
      cs_p0   <= spi_cs;  cs_p1   <= cs_p0;
    end
  end

  assign rise = sclk_p1 & ~sclk_p2;

  // Stage p2: shift, count and emit the completed byte
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt     <= 3'd0;
      vld_p2      <= 1'b0;
      byte_data   <= 8'd0;
      byte_is_cmd <= 1'b0;
    end else begin
      vld_p2 <= 1'b0;
      if (cs_p1) begin
        bit_cnt <= 3'd0;
      end else if (rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          vld_p2      <= 1'b1;
          byte_data   <= {shreg, din_p1};
          byte_is_cmd <= ~dc_p1;
        end
      end
    end
  end

  // Partial bits need no reset: the counter forces eight fresh shifts per byte
  always_ff @(posedge clk) begin
    if (!cs_p1 && rise) shreg <= {shreg[5:0], din_p1};
  end

  assign byte_valid = vld_p2 & ~rst;

endmodule

// File: rtl/ili9341_spi_sink.sv
// ILI9341 serial receiver: decodes commands, tracks the column/page window
// and turns RAMWR/RAMWRC data into addressed RGB565 pixel strobes.
module ili9341_spi_sink
  import ili9341_pkg::*;
#(
  parameter int COL_MAX = 239,
  parameter int ROW_MAX = 319
) (
  input  logic        sysclk,
  input  logic        rst,
  input  logic        spi_clk,
  input  logic        spi_din,
  input  logic        spi_dc,
  input  logic        spi_cs,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_is_cmd,
  output logic        pix_valid,
  output logic [8:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [15:0] pix_rgb,
  output logic [7:0]  cur_cmd
);

  localparam coord_t COL_END = coord_t'(COL_MAX);
  localparam coord_t ROW_END = coord_t'(ROW_MAX);

  dec_state_t  state_q, state_d;
  logic [1:0]  pcnt_q;
  logic        s_hi_q, e_hi_q;
  logic [7:0]  s_lo_q;
  coord_t      sc_q, ec_q, sp_q, ep_q, x_q, y_q, px_q, py_q;
  coord_t      x_adv, y_adv, start_v, end_v;
  logic [7:0]  hi_q;
  logic        hi_pend_q;
  logic [15:0] rgb_q;
  logic        pix_fire, last_param, in_param;

  ili9341_spi_deser u_deser (
    .clk        (sysclk),
    .rst        (rst),
    .spi_clk    (spi_clk),
    .spi_din    (spi_din),
    .spi_dc     (spi_dc),
    .spi_cs     (spi_cs),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_is_cmd(byte_is_cmd)
  );

  assign in_param = (state_q == ST_CASET) || (state_q == ST_PASET);

  always_comb begin
    state_d    = state_q;
    last_param = 1'b0;
    pix_fire   = 1'b0;
    start_v    = {s_hi_q, s_lo_q};
    end_v      = {e_hi_q, byte_data};
    x_adv      = x_q + 9'd1;
    y_adv      = y_q;
    if (x_q == ec_q) begin
      x_adv = sc_q;
      y_adv = (y_q == ep_q) ? sp_q : y_q + 9'd1;
    end
    if (byte_valid) begin
      if (byte_is_cmd) begin
        case (byte_data)
          CMD_CASET:              state_d = ST_CASET;
          CMD_PASET:              state_d = ST_PASET;
          CMD_RAMWR, CMD_RAMWRC:  state_d = ST_RAMWR;
          CMD_SWRESET:            state_d = ST_IDLE;
          default:                state_d = ST_IGNORE;
        endcase
      end else begin
        last_param = in_param && (pcnt_q == 2'd3);
        if (last_param) state_d = ST_IGNORE;
        pix_fire = (state_q == ST_RAMWR) && hi_pend_q;
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      pcnt_q    <= 2'd0;
      hi_pend_q <= 1'b0;
      cur_cmd   <= 8'd0;
      sc_q <= '0; ec_q <= COL_END; sp_q <= '0; ep_q <= ROW_END;
      x_q  <= '0; y_q  <= '0;
      px_q <= '0; py_q <= '0; rgb_q <= 16'd0;
    end else if (byte_valid) begin
      if (byte_is_cmd) begin
        cur_cmd   <= byte_data;
        pcnt_q    <= 2'd0;
        hi_pend_q <= 1'b0;
        if (byte_data == CMD_RAMWR) begin
          x_q <= sc_q;
          y_q <= sp_q;
        end
        if (byte_data == CMD_SWRESET) begin
          sc_q <= '0; ec_q <= COL_END; sp_q <= '0; ep_q <= ROW_END;
          x_q  <= '0; y_q  <= '0;
        end
      end else begin
        if (in_param) pcnt_q <= pcnt_q + 2'd1;
        // Window commits only once all four parameters have arrived
        if (last_param && state_q == ST_CASET) begin
          sc_q <= start_v; ec_q <= end_v;
        end
        if (last_param && state_q == ST_PASET) begin
          sp_q <= start_v; ep_q <= end_v;
        end
        if (state_q == ST_RAMWR) hi_pend_q <= ~hi_pend_q;
        if (pix_fire) begin
          x_q   <= x_adv;
          y_q   <= y_adv;
          px_q  <= x_q;
          py_q  <= y_q;
          rgb_q <= {hi_q, byte_data};
        end
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (byte_valid && !byte_is_cmd) begin
      if (in_param && pcnt_q == 2'd0) s_hi_q <= byte_data[0];
      if (in_param && pcnt_q == 2'd1) s_lo_q <= byte_data;
      if (in_param && pcnt_q == 2'd2) e_hi_q <= byte_data[0];
      if (state_q == ST_RAMWR && !hi_pend_q) hi_q <= byte_data;
    end
  end

  // Pixel outputs show the live pixel on the strobe cycle, then hold it
  assign pix_valid = pix_fire;
  assign pix_x     = pix_fire ? x_q : px_q;
  assign pix_y     = pix_fire ? y_q : py_q;
  assign pix_rgb   = pix_fire ? {hi_q, byte_data} : rgb_q;

endmodule

// File: tb/tb_ili9341_spi_sink.sv
// Directed bench for ili9341_spi_sink: bit-bangs the serial pins at sysclk/4
// and compares logged byte and pixel strobes with hand-computed values.
module tb_ili9341_spi_sink;

  logic        sysclk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_clk = 1'b0, spi_din = 1'b0, spi_dc = 1'b0, spi_cs = 1'b1;
  logic        byte_valid, byte_is_cmd, pix_valid;
  logic [7:0]  byte_data, cur_cmd;
  logic [8:0]  pix_x, pix_y;
  logic [15:0] pix_rgb;

  int n_cmp = 0;
  int n_bad = 0;
  int dbl = 0;
  logic bv_prev = 1'b0, pv_prev = 1'b0;
  logic [8:0]  bq[$];
  logic [33:0] pq[$];

  ili9341_spi_sink dut (
    .sysclk(sysclk), .rst(rst),
    .spi_clk(spi_clk), .spi_din(spi_din), .spi_dc(spi_dc), .spi_cs(spi_cs),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_is_cmd(byte_is_cmd),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .cur_cmd(cur_cmd)
  );

  always #5 sysclk = ~sysclk;

  always @(negedge sysclk) begin
    if (byte_valid) bq.push_back({byte_is_cmd, byte_data});
    if (pix_valid)  pq.push_back({pix_x, pix_y, pix_rgb});
    if ((byte_valid && bv_prev) || (pix_valid && pv_prev)) dbl++;
    bv_prev = byte_valid;
    pv_prev = pix_valid;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] pk(input int x, input int y, input logic [15:0] c);
    return {x[8:0], y[8:0], c};
  endfunction

  function automatic logic [33:0] pix_at(input int i);
    if (i < pq.size()) return pq[i];
    return 'x;
  endfunction

  function automatic logic [8:0] byte_at(input int i);
    if (i < bq.size()) return bq[i];
    return 'x;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input logic dc, input int nbits);
    spi_cs = 1'b0;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_din = b[i];
      spi_dc  = dc;
      tick(2);
      spi_clk = 1'b1;
      tick(2);
      spi_clk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    send_bits(b, dc, 8);
  endtask

  task automatic send_pix(input logic [15:0] c);
    send_byte(c[15:8], 1'b1);
    send_byte(c[7:0], 1'b1);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
  endtask

  logic [15:0] cols[5] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF, 16'h1234};
  int          exx[5]  = '{10, 11, 10, 11, 10};
  int          exy[5]  = '{20, 20, 21, 21, 20};

  initial begin
    reset_dut();
    check("rst_byte_valid", byte_valid, 1'b0);
    check("rst_pix_valid", pix_valid, 1'b0);
    check("rst_byte_data", byte_data, 8'h00);
    check("rst_cur_cmd", cur_cmd, 8'h00);
    check("rst_pix_xy", {pix_x, pix_y}, 18'd0);
    check("rst_pix_rgb", pix_rgb, 16'h0000);

    // Single command byte
    send_byte(8'hA5, 1'b0);
    tick(6);
    check("a5_count", bq.size(), 1);
    check("a5_byte", byte_at(0), {1'b1, 8'hA5});
    check("a5_cur_cmd", cur_cmd, 8'hA5);

    // 2x2 window with wrap back to origin
    bq.delete(); pq.delete();
    send_byte(8'h2A, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h0A, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h0B, 1'b1);
    send_byte(8'h2B, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h14, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h15, 1'b1);
    send_byte(8'h2C, 1'b0);
    for (int i = 0; i < 5; i++) send_pix(cols[i]);
    tick(6);
    check("win_pix_count", pq.size(), 5);
    for (int i = 0; i < 5; i++) check($sformatf("win_pix%0d", i), pix_at(i), pk(exx[i], exy[i], cols[i]));
    check("win_cur_cmd", cur_cmd, 8'h2C);

    // Default window, RAMWR then RAMWRC continuation
    reset_dut();
    pq.delete();
    send_byte(8'h2C, 1'b0);
    send_pix(16'h0001); send_pix(16'h0002);
    send_byte(8'h3C, 1'b0);
    send_pix(16'h0003);
    tick(6);
    check("cont_count", pq.size(), 3);
    check("cont_pix0", pix_at(0), pk(0, 0, 16'h0001));
    check("cont_pix1", pix_at(1), pk(1, 0, 16'h0002));
    check("cont_pix2", pix_at(2), pk(2, 0, 16'h0003));

    // CS abort discards the partial byte
    bq.delete();
    send_bits(8'hFF, 1'b1, 5);
    spi_cs = 1'b1;
    tick(6);
    send_byte(8'h3C, 1'b1);
    tick(6);
    spi_cs = 1'b1;
    tick(2);
    check("cs_abort_count", bq.size(), 1);
    check("cs_abort_byte", byte_at(0), {1'b0, 8'h3C});

    // Truncated CASET leaves the window at 0..239
    pq.delete();
    send_byte(8'h2A, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h05, 1'b1);
    send_byte(8'h2C, 1'b0);
    for (int i = 0; i < 241; i++) send_pix(16'(i));
    tick(6);
    check("trunc_count", pq.size(), 241);
    check("trunc_first", pix_at(0), pk(0, 0, 16'd0));
    check("trunc_end_col", pix_at(239), pk(239, 0, 16'd239));
    check("trunc_next_row", pix_at(240), pk(0, 1, 16'd240));

    // SWRESET with a high byte pending
    pq.delete();
    send_byte(8'h2A, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h05, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h06, 1'b1);
    send_byte(8'h2B, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h04, 1'b1);
    send_byte(8'h2C, 1'b0);
    send_pix(16'hABCD);
    send_byte(8'hAB, 1'b1);
    send_byte(8'h01, 1'b0);
    tick(6);
    check("swr_pending_count", pq.size(), 1);
    check("swr_win_pix", pix_at(0), pk(5, 3, 16'hABCD));
    check("swr_cur_cmd", cur_cmd, 8'h01);
    send_byte(8'h2C, 1'b0);
    send_pix(16'h1111); send_pix(16'h2222); send_pix(16'h3333);
    tick(6);
    check("swr_count", pq.size(), 4);
    check("swr_pix0", pix_at(1), pk(0, 0, 16'h1111));
    check("swr_pix1", pix_at(2), pk(1, 0, 16'h2222));
    check("swr_pix2", pix_at(3), pk(2, 0, 16'h3333));

    // Reset between bit 4 and bit 5
    spi_cs = 1'b1;
    tick(4);
    bq.delete(); pq.delete();
    send_bits(8'hF0, 1'b1, 4);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge sysclk);
      check($sformatf("rst_mid_strobe%0d", k), {byte_valid, pix_valid}, 2'b00);
    end
    @(posedge sysclk); #1;
    rst = 1'b0;
    tick(2);
    send_byte(8'h2C, 1'b0);
    tick(6);
    check("rst_mid_count", bq.size(), 1);
    check("rst_mid_byte", byte_at(0), {1'b1, 8'h2C});
    check("rst_mid_cur_cmd", cur_cmd, 8'h2C);
    check("rst_mid_no_pix", pq.size(), 0);

    check("strobe_width", dbl, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
